// File: rtl/async_down_counter.sv
// rtl/async_down_counter.sv - loadable down counter with terminal-count pulse and optional auto-reload
// Optional prescaler on the count tick is built only when DOWN_CNT_PRESCALE_EN is defined.
module async_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Out-of-range parameters leave the counter permanently stalled rather than miscounting
  localparam bit PARAMS_OK = (WIDTH >= 2) && (WIDTH <= 16) && (PRESCALE >= 2) && (PRESCALE <= 256);

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload_r, q_nx;
  logic             tc_nx;
  logic             tick;

`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pcnt, pcnt_nx;

  assign tick = PARAMS_OK && (state == RUN) && en && (pcnt == PW'(PRESCALE - 1));

  always_comb begin
    pcnt_nx = pcnt;
    if (load || (state_nx == IDLE))
      pcnt_nx = '0;
    else if ((state == RUN) && en)
      pcnt_nx = tick ? '0 : pcnt + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcnt <= '0;
    else      pcnt <= pcnt_nx;
  end
`else
  assign tick = PARAMS_OK && en;
`endif

  always_comb begin
    state_nx = state;
    q_nx     = q;
    tc_nx    = 1'b0;
    if (load) begin
      q_nx     = din;
      state_nx = (din != '0) ? RUN : IDLE;
    end else if ((state == RUN) && tick) begin
      if (q > WIDTH'(1)) begin
        q_nx = q - WIDTH'(1);
      end else if (q == WIDTH'(1)) begin
        tc_nx = 1'b1;
        if (auto_reload) begin
          q_nx = reload_r;
        end else begin
          q_nx     = '0;
          state_nx = IDLE;
        end
      end else begin
        // q==0 in RUN is unreachable; fall back to IDLE rather than wrap
        q_nx     = '0;
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      q        <= '0;
      tc       <= 1'b0;
      busy     <= 1'b0;
      reload_r <= '0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      tc    <= tc_nx;
      busy  <= (state_nx == RUN);
      if (load) reload_r <= din;
    end
  end

endmodule

// File: tb/tb_async_down_counter.sv
// tb/tb_async_down_counter.sv - directed self-checking bench for async_down_counter
// Prescale scenario is compiled in only when DOWN_CNT_PRESCALE_EN is defined.
module tb_async_down_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] din;
  logic       auto_reload;
  logic [3:0] q;
  logic       tc;
  logic       busy;

  int checks;
  int failures;

  async_down_counter #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .din        (din),
    .auto_reload(auto_reload),
    .q          (q),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] exp;
    rst = 1'b1; en = 1'b0; load = 1'b0; din = 4'd0; auto_reload = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if ({q, tc, busy} !== exp) begin
      failures++;
      $display("FAIL reset_async act(q,tc,busy)=%b exp=%b", {q, tc, busy}, exp);
    end
    load = 1'b1; din = 4'd5; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if ({q, tc, busy} !== exp) begin
        failures++;
        $display("FAIL reset_held_%0d act(q,tc,busy)=%b exp=%b", i, {q, tc, busy}, exp);
      end
    end
    load = 1'b0;
    rst = 1'b1;
    step;
    checks++;
    if ({q, tc, busy} !== exp) begin
      failures++;
      $display("FAIL reset_release act(q,tc,busy)=%b exp=%b", {q, tc, busy}, exp);
    end
  endtask

  task automatic test_reset_mid_count;
    logic [5:0] exp;
    load = 1'b1; din = 4'h9; en = 1'b0; auto_reload = 1'b0;
    step;
    load = 1'b0;
    step;
    exp = {4'h9, 1'b0, 1'b1};
    checks++;
    if ({q, tc, busy} !== exp) begin
      failures++;
      $display("FAIL midreset_pre act(q,tc,busy)=%b exp=%b", {q, tc, busy}, exp);
    end
    en = 1'b1;
    #1 rst = 1'b0;
    #1;
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if ({q, tc, busy} !== exp) begin
      failures++;
      $display("FAIL midreset_async act(q,tc,busy)=%b exp=%b", {q, tc, busy}, exp);
    end
    step;
    rst = 1'b1;
    step;
    checks++;
    if ({q, tc, busy} !== exp) begin
      failures++;
      $display("FAIL midreset_after act(q,tc,busy)=%b exp=%b", {q, tc, busy}, exp);
    end
    en = 1'b0;
  endtask

  task automatic test_one_shot;
    logic [5:0] exp [6];
    exp = '{{4'd3, 1'b0, 1'b1}, {4'd2, 1'b0, 1'b1}, {4'd1, 1'b0, 1'b1},
            {4'd0, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}};
    load = 1'b1; din = 4'd3; auto_reload = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step;
      load = 1'b0;
      checks++;
      if ({q, tc, busy} !== exp[i]) begin
        failures++;
        $display("FAIL one_shot_%0d act(q,tc,busy)=%b exp=%b", i, {q, tc, busy}, exp[i]);
      end
    end
  endtask

  task automatic test_auto_reload;
    logic [5:0] exp [7];
    exp = '{{4'd2, 1'b0, 1'b1}, {4'd1, 1'b0, 1'b1}, {4'd2, 1'b1, 1'b1},
            {4'd1, 1'b0, 1'b1}, {4'd2, 1'b1, 1'b1}, {4'd1, 1'b0, 1'b1},
            {4'd0, 1'b1, 1'b0}};
    load = 1'b1; din = 4'd2; auto_reload = 1'b1; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step;
      load = 1'b0;
      // dropping auto_reload before the last terminal cycle turns it into a one-shot finish
      if (i == 4) auto_reload = 1'b0;
      checks++;
      if ({q, tc, busy} !== exp[i]) begin
        failures++;
        $display("FAIL auto_reload_%0d act(q,tc,busy)=%b exp=%b", i, {q, tc, busy}, exp[i]);
      end
    end
  endtask

  task automatic test_reload_one_and_zero_load;
    logic [5:0] exp [5];
    exp = '{{4'd1, 1'b0, 1'b1}, {4'd1, 1'b1, 1'b1}, {4'd1, 1'b1, 1'b1},
            {4'd1, 1'b1, 1'b1}, {4'd0, 1'b0, 1'b0}};
    load = 1'b1; din = 4'd1; auto_reload = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      load = 1'b0;
      if (i == 3) begin
        load = 1'b1;
        din  = 4'd0;
      end
      checks++;
      if ({q, tc, busy} !== exp[i]) begin
        failures++;
        $display("FAIL reload1_zero_%0d act(q,tc,busy)=%b exp=%b", i, {q, tc, busy}, exp[i]);
      end
    end
    load = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_enable_gap_load_priority;
    logic [5:0] exp [8];
    logic       en_seq [8];
    exp = '{{4'd5, 1'b0, 1'b1}, {4'd4, 1'b0, 1'b1}, {4'd4, 1'b0, 1'b1},
            {4'd3, 1'b0, 1'b1}, {4'd3, 1'b0, 1'b1}, {4'd2, 1'b0, 1'b1},
            {4'd1, 1'b0, 1'b1}, {4'd7, 1'b0, 1'b1}};
    en_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    load = 1'b1; din = 4'd5; auto_reload = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step;
      load = 1'b0;
      en   = en_seq[i];
      if (i == 6) begin
        load = 1'b1;
        din  = 4'd7;
      end
      checks++;
      if ({q, tc, busy} !== exp[i]) begin
        failures++;
        $display("FAIL en_gap_%0d act(q,tc,busy)=%b exp=%b", i, {q, tc, busy}, exp[i]);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

`ifdef DOWN_CNT_PRESCALE_EN
  task automatic test_prescale;
    logic [5:0] exp [9];
    exp = '{{4'd2, 1'b0, 1'b1}, {4'd2, 1'b0, 1'b1}, {4'd2, 1'b0, 1'b1},
            {4'd2, 1'b0, 1'b1}, {4'd1, 1'b0, 1'b1}, {4'd1, 1'b0, 1'b1},
            {4'd1, 1'b0, 1'b1}, {4'd1, 1'b0, 1'b1}, {4'd0, 1'b1, 1'b0}};
    load = 1'b1; din = 4'd2; auto_reload = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step;
      load = 1'b0;
      checks++;
      if ({q, tc, busy} !== exp[i]) begin
        failures++;
        $display("FAIL prescale_%0d act(q,tc,busy)=%b exp=%b", i, {q, tc, busy}, exp[i]);
      end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_reset_mid_count;
    test_one_shot;
    test_auto_reload;
    test_reload_one_and_zero_load;
    test_enable_gap_load_priority;
`ifdef DOWN_CNT_PRESCALE_EN
    test_prescale;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
